// File: rtl/ysyx_25040111_icache_pkg.sv
// Shared definitions for the instruction cache: FSM state encodings,
// AXI4 read-channel constants and a small response-decoding helper.
package ysyx_25040111_icache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_AR     = 3'd2,
        ST_R      = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Any response code other than OKAY marks the refill as faulty.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/ysyx_25040111_icache_array.sv
// Tag/data/valid storage for the direct-mapped icache. Asynchronous read
// port, one word-write port used by the refill, a tag write that can also
// validate the line, and a flash clear of every valid bit.
module ysyx_25040111_icache_array #(
    parameter int NLINES     = 16,
    parameter int LINE_WORDS = 4,
    localparam int IDX_W     = $clog2(NLINES),
    localparam int WORD_W    = $clog2(LINE_WORDS),
    localparam int TAG_W     = 32 - IDX_W - WORD_W - 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [WORD_W-1:0] rd_word,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [31:0]       rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [31:0]       wr_data,
    input  logic              tag_we,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              set_valid,
    input  logic              flash_clr
);

    logic [NLINES-1:0] valid_r;
    logic [TAG_W-1:0]  tag_r  [NLINES];
    logic [31:0]       data_r [NLINES][LINE_WORDS];

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_data  = data_r[rd_idx][rd_word];

    // Valid bits: a flash clear always wins over validating a refilled line.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r <= '0;
        end else if (flash_clr) begin
            valid_r <= '0;
        end else if (tag_we && set_valid) begin
            valid_r[wr_idx] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them.
    always_ff @(posedge clock) begin
        if (tag_we) begin
            tag_r[wr_idx] <= wr_tag;
        end
        if (wr_en) begin
            data_r[wr_idx][wr_word] <= wr_data;
        end
    end

endmodule

// File: rtl/ysyx_25040111_icache.sv
// Direct-mapped read-only instruction cache. One fetch at a time: hits
// answer in the LOOKUP cycle, misses refill the whole line with a single
// AXI4 INCR burst and answer from the RESP state. fence_i drops all lines.
module ysyx_25040111_icache
    import ysyx_25040111_icache_pkg::*;
#(
    parameter int NLINES     = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_valid,
    input  logic [31:0] ifu_addr,
    output logic        ifu_ready,
    output logic [31:0] ifu_inst,
    output logic        ifu_fault,
    input  logic        fence_i,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(NLINES);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;

    state_e             state_r;
    state_e             state_s;
    logic [31:2]        req_addr_r;
    logic [WORD_W-1:0]  beat_r;
    logic               err_r;
    logic               fence_pend_r;
    logic [31:0]        resp_word_r;

    logic [IDX_W-1:0]   idx_s;
    logic [WORD_W-1:0]  word_s;
    logic [TAG_W-1:0]   tag_s;
    logic               rd_valid_s;
    logic [TAG_W-1:0]   rd_tag_s;
    logic [31:0]        rd_data_s;
    logic               hit_s;
    logic               beat_fire_s;
    logic               beat_err_s;
    logic               err_next_s;
    logic               last_s;
    logic               set_valid_s;
    logic               unused_s;

    // Byte offset within a word is irrelevant for word fetches.
    assign unused_s = ^ifu_addr[1:0];

    assign idx_s       = req_addr_r[OFF_W +: IDX_W];
    assign word_s      = req_addr_r[2 +: WORD_W];
    assign tag_s       = req_addr_r[31 -: TAG_W];
    assign hit_s       = rd_valid_s && (rd_tag_s == tag_s);
    assign beat_fire_s = (state_r == ST_R) && rvalid;
    assign beat_err_s  = beat_fire_s && resp_is_err(rresp);
    assign err_next_s  = err_r | beat_err_s;
    assign last_s      = beat_fire_s && rlast;
    // A fence seen at any point of the refill, including the last beat, keeps the line invalid.
    assign set_valid_s = !err_next_s && !fence_pend_r && !fence_i;

    // The address is fixed for the whole transaction, so it is stable until arready.
    assign araddr  = {req_addr_r[31:OFF_W], {OFF_W{1'b0}}};
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;

    ysyx_25040111_icache_array #(
        .NLINES     (NLINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clock     (clock),
        .reset     (reset),
        .rd_idx    (idx_s),
        .rd_word   (word_s),
        .rd_valid  (rd_valid_s),
        .rd_tag    (rd_tag_s),
        .rd_data   (rd_data_s),
        .wr_en     (beat_fire_s),
        .wr_idx    (idx_s),
        .wr_word   (beat_r),
        .wr_data   (rdata),
        .tag_we    (last_s),
        .wr_tag    (tag_s),
        .set_valid (set_valid_s),
        .flash_clr (fence_i)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ifu_valid) state_s = ST_LOOKUP;
                else           state_s = ST_IDLE;
            end
            ST_LOOKUP: begin
                if (hit_s) state_s = ST_IDLE;
                else       state_s = ST_AR;
            end
            ST_AR: begin
                if (arready) state_s = ST_R;
                else         state_s = ST_AR;
            end
            ST_R: begin
                if (last_s) state_s = ST_RESP;
                else        state_s = ST_R;
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: fetch response and AXI handshake strobes.
    always_comb begin
        ifu_ready = 1'b0;
        ifu_inst  = 32'h0000_0000;
        ifu_fault = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        case (state_r)
            ST_LOOKUP: begin
                if (hit_s) begin
                    ifu_ready = 1'b1;
                    ifu_inst  = rd_data_s;
                end else begin
                    ifu_ready = 1'b0;
                end
            end
            ST_AR: arvalid = 1'b1;
            ST_R:  rready  = 1'b1;
            ST_RESP: begin
                ifu_ready = 1'b1;
                ifu_fault = err_r;
                ifu_inst  = err_r ? 32'h0000_0000 : resp_word_r;
            end
            default: ifu_ready = 1'b0;
        endcase
    end

    // Capture the fetch address when a request is accepted in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_addr_r <= '0;
        end else if ((state_r == ST_IDLE) && ifu_valid) begin
            req_addr_r <= ifu_addr[31:2];
        end else begin
            req_addr_r <= req_addr_r;
        end
    end

    // Beat counter: advances per accepted beat, wraps to 0 on rlast.
    always_ff @(posedge clock) begin
        if (reset || last_s) begin
            beat_r <= '0;
        end else if (beat_fire_s) begin
            beat_r <= beat_r + 1'b1;
        end else begin
            beat_r <= beat_r;
        end
    end

    // Keep the requested word as it streams past during the refill.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_word_r <= 32'h0000_0000;
        end else if (beat_fire_s && (beat_r == word_s)) begin
            resp_word_r <= rdata;
        end else begin
            resp_word_r <= resp_word_r;
        end
    end

    // Sticky bus-error flag for the current refill, cleared after the response.
    always_ff @(posedge clock) begin
        if (reset || (state_r == ST_RESP)) begin
            err_r <= 1'b0;
        end else if (beat_err_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Remember a fence that lands while a refill is in flight.
    always_ff @(posedge clock) begin
        if (reset || (state_s == ST_IDLE)) begin
            fence_pend_r <= 1'b0;
        end else if (fence_i && ((state_r == ST_AR) || (state_r == ST_R))) begin
            fence_pend_r <= 1'b1;
        end else begin
            fence_pend_r <= fence_pend_r;
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_icache.sv
// Scoreboard bench for the icache: request tasks push the expected response,
// a negedge monitor pops and compares on every ifu_ready pulse; the tasks
// also play the AXI slave with hand-written line contents.
module tb_ysyx_25040111_icache;

    localparam int NLINES     = 16;
    localparam int LINE_WORDS = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ifu_valid = 1'b0;
    logic [31:0] ifu_addr = 32'h0;
    logic        ifu_ready;
    logic [31:0] ifu_inst;
    logic        ifu_fault;
    logic        fence_i = 1'b0;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rlast = 1'b0;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   resp_cnt = 0;
    int   ar_cnt = 0;
    logic arvalid_prev = 1'b0;

    localparam logic [127:0] LINE_A = 128'h00000044_00000033_00000022_00000011;
    localparam logic [127:0] LINE_B = 128'h000000B4_000000B3_000000B2_000000B1;
    localparam logic [127:0] LINE_C = 128'h000000C4_000000C3_000000C2_000000C1;

    always #5 clock = ~clock;

    ysyx_25040111_icache #(
        .NLINES     (NLINES),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ifu_valid (ifu_valid),
        .ifu_addr  (ifu_addr),
        .ifu_ready (ifu_ready),
        .ifu_inst  (ifu_inst),
        .ifu_fault (ifu_fault),
        .fence_i   (fence_i),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: count new AR requests and score every response pulse.
    always @(negedge clock) begin
        exp_t e;
        if (arvalid === 1'b1 && arvalid_prev !== 1'b1) ar_cnt++;
        arvalid_prev = arvalid;
        if (ifu_ready === 1'b1) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got inst %h with no pending request", ifu_inst);
            end else begin
                e = exp_q.pop_front();
                chk("resp_inst", ifu_inst, e.inst);
                chk("resp_fault", 32'(ifu_fault), 32'(e.fault));
            end
        end
    end

    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] exp_inst, input logic fence_lookup);
        int   ar0;
        exp_t e;
        @(negedge clock);
        ar0 = ar_cnt;
        ifu_valid = 1'b1;
        ifu_addr  = addr;
        e.inst = exp_inst;
        e.fault = 1'b0;
        exp_q.push_back(e);
        @(negedge clock);
        ifu_valid = 1'b0;
        fence_i   = fence_lookup;
        chk("hit_latency", 32'(ifu_ready), 32'd1);
        @(negedge clock);
        fence_i = 1'b0;
        chk("hit_no_ar", 32'(ar_cnt), 32'(ar0));
    endtask

    task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] exp_araddr,
                              input logic [127:0] line, input logic [31:0] exp_inst,
                              input logic exp_fault, input int err_beat, input int ar_wait,
                              input int gap, input int fence_beat);
        int   ar0;
        int   r0;
        int   t;
        exp_t e;
        @(negedge clock);
        ar0 = ar_cnt;
        r0  = resp_cnt;
        ifu_valid = 1'b1;
        ifu_addr  = addr;
        e.inst = exp_inst;
        e.fault = exp_fault;
        exp_q.push_back(e);
        @(negedge clock);
        ifu_valid = 1'b0;
        chk("miss_lookup_ready", 32'(ifu_ready), 32'd0);
        t = 0;
        while (arvalid !== 1'b1 && t < 8) begin
            @(negedge clock);
            t++;
        end
        chk("ar_valid", 32'(arvalid), 32'd1);
        chk("araddr", araddr, exp_araddr);
        chk("arlen", 32'(arlen), 32'(LINE_WORDS - 1));
        chk("arsize", 32'(arsize), 32'd2);
        chk("arburst", 32'(arburst), 32'd1);
        chk("rready_in_ar", 32'(rready), 32'd0);
        for (int k = 0; k < ar_wait; k++) begin
            @(negedge clock);
            chk("ar_hold_valid", 32'(arvalid), 32'd1);
            chk("ar_hold_addr", araddr, exp_araddr);
        end
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            for (int g = 0; g < gap; g++) begin
                chk("rready_gap", 32'(rready), 32'd1);
                @(negedge clock);
            end
            chk("rready", 32'(rready), 32'd1);
            rvalid  = 1'b1;
            rdata   = line[i*32 +: 32];
            rresp   = (i == err_beat) ? 2'b10 : 2'b00;
            rlast   = (i == LINE_WORDS - 1);
            fence_i = (i == fence_beat);
            @(negedge clock);
            rvalid  = 1'b0;
            rlast   = 1'b0;
            rresp   = 2'b00;
            fence_i = 1'b0;
        end
        chk("rready_after_last", 32'(rready), 32'd0);
        t = 0;
        while (resp_cnt == r0 && t < 8) begin
            @(negedge clock);
            t++;
        end
        chk("miss_resp_seen", 32'(resp_cnt), 32'(r0 + 1));
        chk("miss_one_ar", 32'(ar_cnt), 32'(ar0 + 1));
    endtask

    task automatic pulse_fence();
        @(negedge clock);
        fence_i = 1'b1;
        @(negedge clock);
        fence_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        repeat (3) @(negedge clock);
        chk("rst_ifu_ready", 32'(ifu_ready), 32'd0);
        chk("rst_ifu_fault", 32'(ifu_fault), 32'd0);
        chk("rst_ifu_inst", ifu_inst, 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        reset = 1'b0;

        // Cold miss, then hit on the same line.
        fetch_miss(32'h8000_0000, 32'h8000_0000, LINE_A, 32'h11, 1'b0, -1, 0, 0, -1);
        fetch_hit(32'h8000_0008, 32'h33, 1'b0);
        // Conflict eviction on index 0 and refetch (arready stall, rvalid gaps).
        fetch_miss(32'h8000_0104, 32'h8000_0100, LINE_B, 32'hB2, 1'b0, -1, 0, 0, -1);
        fetch_miss(32'h8000_0000, 32'h8000_0000, LINE_A, 32'h11, 1'b0, -1, 5, 2, -1);
        // Fence in IDLE, then a refill that reports a bus error on beat 1.
        pulse_fence();
        fetch_miss(32'h8000_000C, 32'h8000_0000, LINE_A, 32'h0, 1'b1, 1, 0, 0, -1);
        fetch_miss(32'h8000_000C, 32'h8000_0000, LINE_A, 32'h44, 1'b0, -1, 0, 0, -1);
        fetch_hit(32'h8000_0004, 32'h22, 1'b0);
        // Fence while in R: word still returned, line stays invalid.
        fetch_miss(32'h8000_0104, 32'h8000_0100, LINE_B, 32'hB2, 1'b0, -1, 0, 0, -1);
        fetch_miss(32'h8000_0004, 32'h8000_0000, LINE_A, 32'h22, 1'b0, -1, 0, 1, 2);
        fetch_miss(32'h8000_0004, 32'h8000_0000, LINE_A, 32'h22, 1'b0, -1, 0, 0, -1);
        fetch_hit(32'h8000_000C, 32'h44, 1'b0);
        // Fence in the same cycle as a hit: old data returned, next fetch misses.
        fetch_hit(32'h8000_0000, 32'h11, 1'b1);
        fetch_miss(32'h8000_0000, 32'h8000_0000, LINE_A, 32'h11, 1'b0, -1, 0, 0, -1);
        // Another index does not disturb index 0.
        fetch_miss(32'h8000_0014, 32'h8000_0010, LINE_C, 32'hC2, 1'b0, -1, 1, 0, -1);
        fetch_hit(32'h8000_0018, 32'hC3, 1'b0);
        fetch_hit(32'h8000_0000, 32'h11, 1'b0);

        // Reset in the middle of a refill.
        @(negedge clock);
        ifu_valid = 1'b1;
        ifu_addr  = 32'h8000_0020;
        @(negedge clock);
        ifu_valid = 1'b0;
        t = 0;
        while (arvalid !== 1'b1 && t < 8) begin
            @(negedge clock);
            t++;
        end
        chk("rst_test_ar", 32'(arvalid), 32'd1);
        arready = 1'b1;
        @(negedge clock);
        arready = 1'b0;
        chk("rst_test_in_r", 32'(rready), 32'd1);
        rvalid = 1'b1;
        rdata  = 32'h55;
        @(negedge clock);
        rvalid = 1'b0;
        reset  = 1'b1;
        @(negedge clock);
        chk("midrst_rready", 32'(rready), 32'd0);
        chk("midrst_arvalid", 32'(arvalid), 32'd0);
        chk("midrst_ifu_ready", 32'(ifu_ready), 32'd0);
        reset = 1'b0;
        fetch_miss(32'h8000_0000, 32'h8000_0000, LINE_A, 32'h11, 1'b0, -1, 0, 0, -1);

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
